// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// FSM states, instruction classes from ctrl, error codes, watchdog sizing.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_ILLEGAL = 3'd7
    } ins_class_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_FETCH_TO = 2'd2;
    localparam logic [1:0] ERR_MEM_TO   = 2'd3;

    // Counter width for a watchdog limit; a disabled watchdog still gets one bit.
    function automatic int timer_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Watchdog for memory waits: counts consecutive waiting cycles and flags
// expiry on the last permitted waiting cycle. LIMIT = 0 never expires.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int LIMIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = timer_width(LIMIT);
    localparam logic [TW-1:0] LAST = (LIMIT > 0) ? TW'(LIMIT - 1) : '0;

    logic [TW-1:0] count;

    // Waiting-cycle counter: clear has priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    // Expiring here lets the request stay up for exactly LIMIT cycles.
    assign expire = (LIMIT > 0) && en && (count == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/EXEC/MEM/WB per
// instruction class, emits phase-timed write strobes and memory requests,
// counts retired instructions, supports halt at instruction boundaries and
// a sticky error state for illegal ops and memory timeouts.
//
// Handshake: im_req/dm_req rise when the FSM enters the wait state and stay
// high until the matching ready is seen high at a clock edge; the transfer
// completes in that cycle. A request is only dropped by a watchdog expiry.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ins_class,
    input  logic             br_taken,
    input  logic             halt_req,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             im_req,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             pc_src,
    output logic             reg_wr,
    output logic             dm_req,
    output logic             dm_we,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [2:0]       state
);

    state_t     state_q, state_d;
    ins_class_t cls_q;
    logic [1:0] err_code_d;
    logic       waiting;
    logic       expire;
    logic       retire;

    // A waiting cycle is a request cycle without the matching ready.
    assign waiting = ((state_q == ST_FETCH) && !im_ready) ||
                     ((state_q == ST_MEM)   && !dm_ready);

    mc_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!waiting),
        .en     (waiting),
        .expire (expire)
    );

    // Next-state and strobe decode; strobes depend only on state and inputs.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code;
        im_req     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 1'b0;
        reg_wr     = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_DECODE;
                end else if (expire) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_FETCH_TO;
                end
            end
            ST_DECODE: begin
                if (ins_class == CLS_ILLEGAL) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_ALU_R, CLS_ALU_I: state_d = ST_WB;
                    CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_wr  = br_taken;
                        pc_src = 1'b1;
                        retire = 1'b1;
                    end
                    CLS_JUMP: begin
                        pc_wr  = 1'b1;
                        pc_src = 1'b1;
                        retire = 1'b1;
                    end
                    CLS_JAL: begin
                        pc_wr  = 1'b1;
                        pc_src = 1'b1;
                        reg_wr = 1'b1;
                        retire = 1'b1;
                    end
                    default: begin
                        // DECODE already traps illegal classes; kept for safety.
                        state_d    = ST_ERR;
                        err_code_d = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                dm_req = 1'b1;
                dm_we  = (cls_q == CLS_STORE);
                if (dm_ready) begin
                    if (cls_q == CLS_LOAD) state_d = ST_WB;
                    else                   retire  = 1'b1;
                end else if (expire) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_MEM_TO;
                end
            end
            ST_WB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
            end
            ST_HALT: begin
                if (!halt_req) state_d = ST_FETCH;
            end
            ST_ERR: state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
        // Instruction boundary: halt_req is only honoured here.
        if (retire) state_d = halt_req ? ST_HALT : ST_FETCH;
    end

    // State, latched class, error code and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RST;
            cls_q    <= CLS_ALU_R;
            err_code <= ERR_NONE;
            retired  <= '0;
        end else begin
            state_q  <= state_d;
            err_code <= err_code_d;
            if (state_q == ST_DECODE) cls_q <= ins_class_t'(ins_class);
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    assign instr_done = retire;
    assign halted     = (state_q == ST_HALT);
    assign err        = (state_q == ST_ERR);
    assign state      = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed and random instruction streams against a
// per-class timing/strobe table model, plus halt, illegal-op and timeouts.
module tb_mc_sequencer;
    import mc_pkg::*;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       ins_class = 3'd0;
    logic             br_taken = 1'b0;
    logic             halt_req = 1'b0;
    logic             im_ready = 1'b0;
    logic             dm_ready = 1'b0;
    logic             im_req, ir_wr, pc_wr, pc_src, reg_wr, dm_req, dm_we;
    logic             instr_done, halted, err;
    logic [CNT_W-1:0] retired;
    logic [1:0]       err_code;
    logic [2:0]       state;

    mc_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_class  (ins_class),
        .br_taken   (br_taken),
        .halt_req   (halt_req),
        .im_ready   (im_ready),
        .dm_ready   (dm_ready),
        .im_req     (im_req),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .reg_wr     (reg_wr),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .instr_done (instr_done),
        .retired    (retired),
        .halted     (halted),
        .err        (err),
        .err_code   (err_code),
        .state      (state)
    );

    // ---------------- clock / global time limit ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  lat;
        logic [7:0]  ir_at;
        logic [7:0]  reg_at;
        logic [7:0]  n_reg;
        logic [7:0]  n_dmreq;
        logic [7:0]  n_dmwe;
        logic [7:0]  n_pc_seq;
        logic [7:0]  n_pc_tgt;
        logic [7:0]  n_jal;
        logic [31:0] ret_before;
    } exp_t;
    localparam int EW = $bits(exp_t);
    logic [EW-1:0] exp_q[$];

    // Timing and strobe totals for one instruction from the class table.
    function automatic exp_t model(input int cls, input bit taken, input int fw, input int dw,
                                   input int ret_before);
        exp_t e;
        int   base;
        bit   is_mem;
        bit   has_reg;
        e       = '0;
        is_mem  = (cls == 2) || (cls == 3);
        has_reg = (cls == 0) || (cls == 1) || (cls == 2) || (cls == 6);
        case (cls)
            0, 1:    base = 4;
            2:       base = 5;
            3:       base = 4;
            default: base = 3;
        endcase
        e.lat        = 8'(base + fw + (is_mem ? dw : 0));
        e.ir_at      = 8'(fw + 1);
        e.reg_at     = has_reg ? e.lat : 8'd0;
        e.n_reg      = has_reg ? 8'd1 : 8'd0;
        e.n_dmreq    = is_mem ? 8'(dw + 1) : 8'd0;
        e.n_dmwe     = (cls == 3) ? 8'(dw + 1) : 8'd0;
        e.n_pc_seq   = 8'd1;
        e.n_pc_tgt   = (cls == 5 || cls == 6) ? 8'd1 : (cls == 4) ? 8'(taken) : 8'd0;
        e.n_jal      = (cls == 6) ? 8'd1 : 8'd0;
        e.ret_before = 32'(ret_before);
        return e;
    endfunction

    // ---------------- memory responders ----------------
    int fw_cur = 0;
    int dw_cur = 0;
    int im_cnt = 0;
    int dm_cnt = 0;

    // Ready after the configured number of request cycles, settled mid-cycle.
    always @(posedge clk) begin
        #2;
        if (im_req) begin
            im_ready = (im_cnt >= fw_cur);
            im_cnt   = im_ready ? 0 : im_cnt + 1;
        end else begin
            im_ready = 1'b0;
            im_cnt   = 0;
        end
        if (dm_req) begin
            dm_ready = (dm_cnt >= dw_cur);
            dm_cnt   = dm_ready ? 0 : dm_cnt + 1;
        end else begin
            dm_ready = 1'b0;
            dm_cnt   = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit m_active = 0;
    int m_lat, m_ir_at, m_reg_at, m_nreg, m_ndmreq, m_ndmwe, m_pc_seq, m_pc_tgt, m_jal;
    int viol = 0;

    // Track each instruction from its first fetch cycle and score it on retire.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            m_active = 0;
        end else begin
            if ((int'(ir_wr) + int'(reg_wr) + int'(dm_req)) > 1) viol++;
            if (dm_we && !dm_req) viol++;
            if ((halted || err) && (im_req || ir_wr || pc_wr || reg_wr || dm_req || instr_done)) viol++;
            if (!m_active && im_req) begin
                m_active = 1;
                m_lat = 0; m_ir_at = 0; m_reg_at = 0; m_nreg = 0; m_ndmreq = 0;
                m_ndmwe = 0; m_pc_seq = 0; m_pc_tgt = 0; m_jal = 0;
            end
            if (m_active) begin
                m_lat++;
                if (ir_wr && m_ir_at == 0) m_ir_at = m_lat;
                if (reg_wr) begin
                    m_nreg++;
                    if (m_reg_at == 0) m_reg_at = m_lat;
                end
                if (dm_req) m_ndmreq++;
                if (dm_we) m_ndmwe++;
                if (pc_wr && !pc_src) m_pc_seq++;
                if (pc_wr && pc_src) m_pc_tgt++;
                if (pc_wr && reg_wr) m_jal++;
                if (instr_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", m_lat, e.lat);
                        check("ir_wr_cycle", m_ir_at, e.ir_at);
                        check("reg_wr_cycle", m_reg_at, e.reg_at);
                        check("reg_wr_count", m_nreg, e.n_reg);
                        check("dm_req_cycles", m_ndmreq, e.n_dmreq);
                        check("dm_we_cycles", m_ndmwe, e.n_dmwe);
                        check("pc_wr_seq", m_pc_seq, e.n_pc_seq);
                        check("pc_wr_target", m_pc_tgt, e.n_pc_tgt);
                        check("jal_pc_reg", m_jal, e.n_jal);
                        check("retired_at_done", retired, e.ret_before);
                    end
                    m_active = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    int exp_retired = 0;
    bit in_halt = 0;

    // Entered at posedge+1; leaves one cycle after reset release in FETCH.
    task automatic reset_dut();
        rst       = 1'b0;
        halt_req  = 1'b0;
        ins_class = 3'd0;
        br_taken  = 1'b0;
        fw_cur    = 0;
        dw_cur    = 0;
        exp_retired = 0;
        in_halt   = 0;
        repeat (3) begin
            @(negedge clk);
            check("reset_strobes", {im_req, ir_wr, pc_wr, pc_src, reg_wr, dm_req, dm_we,
                                    instr_done, halted, err}, 0);
            check("reset_state", state, ST_RST);
        end
        check("reset_retired", retired, 0);
        check("reset_err_code", err_code, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_to_fetch", state, ST_FETCH);
    endtask

    // Entered at posedge+1 of a fresh FETCH cycle, or of a HALT cycle.
    task automatic run_instr(input int cls, input bit taken, input bit hreq, input int fw, input int dw);
        bit got;
        int k;
        ins_class = 3'(cls);
        br_taken  = taken;
        fw_cur    = fw;
        dw_cur    = dw;
        exp_q.push_back(model(cls, taken, fw, dw, exp_retired));
        exp_retired++;
        if (in_halt) begin
            halt_req = 1'b0;
            @(posedge clk); #1;
            check("halt_release_fetch", state, ST_FETCH);
            in_halt = 0;
        end
        halt_req = hreq;
        got = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (instr_done) begin
                got = 1;
                break;
            end
        end
        if (!got) check("retire_wait", 0, 1);
        @(posedge clk); #1;
        check("retired_count", retired, 32'(exp_retired));
        if (hreq) begin
            check("halt_state", state, ST_HALT);
            check("halted_flag", halted, 1);
            k = $urandom_range(0, 2);
            repeat (k) begin
                @(posedge clk); #1;
                check("halt_hold", halted, 1);
            end
            in_halt = 1;
        end else begin
            check("fetch_after_retire", state, ST_FETCH);
        end
    endtask

    // Watches an error case: counts request cycles until err rises.
    task automatic expect_error(input string name, input logic [1:0] code, input int req_cycles,
                                input bit use_dm);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err) begin
                seen = 1;
                break;
            end
            if (use_dm ? dm_req : im_req) n++;
        end
        check({name, "_err_seen"}, seen, 1);
        check({name, "_req_cycles"}, n, req_cycles);
        check({name, "_err_code"}, err_code, code);
        repeat (4) @(negedge clk);
        check({name, "_sticky_state"}, state, ST_ERR);
        check({name, "_quiet"}, {im_req, dm_req, instr_done}, 0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        @(posedge clk); #1;
        reset_dut();

        // directed: ALU_R, delayed LOAD, branches, jumps, halted STORE, waited fetch
        run_instr(0, 0, 0, 0, 0);
        run_instr(2, 0, 0, 0, 3);
        run_instr(4, 0, 0, 0, 0);
        run_instr(4, 1, 0, 0, 0);
        run_instr(6, 0, 0, 0, 0);
        run_instr(5, 0, 0, 1, 0);
        run_instr(3, 0, 1, 0, 2);
        run_instr(1, 0, 0, 2, 0);
        run_instr(3, 0, 0, 3, 3);

        // random stream; waits stay below the watchdog limit
        for (int i = 0; i < 40; i++) begin
            run_instr($urandom_range(0, 6), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0), $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1));
        end
        if (in_halt) run_instr(0, 0, 0, 0, 0);

        // illegal class: FETCH, DECODE, then ERR
        reset_dut();
        ins_class = 3'd7;
        expect_error("illegal", ERR_ILLEGAL, 1, 0);

        // fetch timeout: im_ready never arrives
        reset_dut();
        fw_cur = 1000;
        expect_error("fetch_to", ERR_FETCH_TO, TO, 0);

        // memory timeout on a load
        reset_dut();
        ins_class = 3'd2;
        dw_cur = 1000;
        expect_error("mem_to", ERR_MEM_TO, TO, 1);

        // reset leaves ERR and clears the error state
        reset_dut();
        check("err_cleared", err, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        check("strobe_invariants", viol, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
